// File: rtl/io_tx_scheduler_pkg.sv
// Shared constants and types for the UART-lite TX scheduler slice:
// register map, status bits, AXI response codes and the engine FSM states.
package io_pkg;

  localparam logic [31:0] UART_RX_OFFS   = 32'd0;
  localparam logic [31:0] UART_TX_OFFS   = 32'd4;
  localparam logic [31:0] UART_STAT_OFFS = 32'd8;

  localparam int unsigned STAT_RX_VALID = 0;
  localparam int unsigned STAT_TX_EMPTY = 2;
  localparam int unsigned STAT_TX_FULL  = 3;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_ISSUE,
    TX_WAIT_W,
    TX_WAIT_AW,
    TX_RESP
  } tx_state_t;

endpackage

// File: rtl/io_tx_scheduler_if.sv
// AXI4-lite write-only channel bundle between the TX scheduler (master)
// and the UART-lite register slave.
interface io_tx_axi_if;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [1:0]  axi_bresp;

  modport master (
    output axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata,
           axi_wstrb, axi_bready,
    input  axi_awready, axi_wready, axi_bvalid, axi_bresp
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awprot, axi_wvalid, axi_wdata,
           axi_wstrb, axi_bready,
    output axi_awready, axi_wready, axi_bvalid, axi_bresp
  );
endinterface

// File: rtl/io_word_fifo.sv
// Synchronous word FIFO; full/empty derive from the registered count, so a
// push is visible to the reader one cycle later.
module io_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/io_tx_scheduler.sv
// Queues core output words and streams them byte-wise (LSB first) into the
// UART-lite TX FIFO over AXI4-lite, gated by a status-refreshed credit count.
module io_tx_scheduler
  import io_pkg::*;
#(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned QUEUE_DEPTH    = 16,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned TX_DEPTH       = 16,
  parameter logic [31:0] TX_FIFO_ADDR   = 32'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_req,
  input  logic [WORD_W-1:0] out_data,
  output logic              out_busy,
  input  logic [31:0]       stat_reg,
  input  logic              stat_reg_new,
  io_tx_axi_if.master       axi,
  output logic              tx_idle,
  output logic              tx_err,
  output logic [31:0]       tx_byte_count
);
  localparam int unsigned IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned CRED_W = $clog2(TX_DEPTH + 1);
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  tx_state_t         state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              awvalid_q, wvalid_q, bready_q;
  logic [31:0]       awaddr_q;
  logic [7:0]        wdata_q, head_byte;
  logic              err_q, idle_q;
  logic [31:0]       bytes_q;

  logic              q_full, q_empty, q_pop;
  logic [WORD_W-1:0] q_head;
  logic [CNT_W-1:0]  q_count;
  logic              issue, b_done;

  io_word_fifo #(.WIDTH(WORD_W), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (out_req),
    .data_i  (out_data),
    .pop_i   (q_pop),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (q_head),
    .count_o (q_count)
  );

  assign issue  = (state_q == TX_IDLE) && !q_empty && (credits_q != '0);
  assign b_done = (state_q == TX_RESP) && axi.axi_bvalid;
  assign q_pop  = b_done && (idx_q == LAST_IDX);

  always_comb begin
    head_byte = '0;
    for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
      if (idx_q == IDX_W'(b)) head_byte = q_head[8*b +: 8];
    end
  end

  // TX-full wins; an empty refresh is only trusted while no write is in flight
  always_comb begin
    credits_d = credits_q;
    if (stat_reg_new && stat_reg[STAT_TX_FULL]) begin
      credits_d = '0;
    end else if (stat_reg_new && stat_reg[STAT_TX_EMPTY] && (state_q == TX_IDLE)) begin
      credits_d = CRED_W'(TX_DEPTH) - CRED_W'(issue);
    end else if (issue) begin
      credits_d = credits_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      idx_q     <= '0;
      credits_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      idle_q    <= 1'b1;
      bytes_q   <= '0;
    end else begin
      credits_q <= credits_d;
      idle_q    <= (q_count == '0) && (state_q == TX_IDLE);
      case (state_q)
        TX_IDLE: begin
          if (issue) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= TX_FIFO_ADDR;
            wdata_q   <= head_byte;
            state_q   <= TX_ISSUE;
          end
        end
        TX_ISSUE: begin
          if (axi.axi_awready && axi.axi_wready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= TX_RESP;
          end else if (axi.axi_awready) begin
            awvalid_q <= 1'b0;
            state_q   <= TX_WAIT_W;
          end else if (axi.axi_wready) begin
            wvalid_q  <= 1'b0;
            state_q   <= TX_WAIT_AW;
          end
        end
        TX_WAIT_W: begin
          if (axi.axi_wready) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= TX_RESP;
          end
        end
        TX_WAIT_AW: begin
          if (axi.axi_awready) begin
            awvalid_q <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= TX_RESP;
          end
        end
        TX_RESP: begin
          if (axi.axi_bvalid) begin
            bready_q <= 1'b0;
            bytes_q  <= bytes_q + 1'b1;
            if (axi.axi_bresp != AXI_OKAY) err_q <= 1'b1;
            idx_q    <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            state_q  <= TX_IDLE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign out_busy        = q_full;
  assign tx_idle         = idle_q;
  assign tx_err          = err_q;
  assign tx_byte_count   = bytes_q;
  assign axi.axi_awvalid = awvalid_q;
  assign axi.axi_awaddr  = awaddr_q;
  assign axi.axi_awprot  = '0;
  assign axi.axi_wvalid  = wvalid_q;
  assign axi.axi_wdata   = {24'b0, wdata_q};
  assign axi.axi_wstrb   = 4'b0001;
  assign axi.axi_bready  = bready_q;
endmodule

// File: tb/tb_io_tx_scheduler.sv
// Scoreboard bench for io_tx_scheduler: pushes queue expected bytes, a
// negedge slave/monitor process answers AXI and checks every write.
module tb_io_tx_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        out_req;
  logic [31:0] out_data;
  logic        out_busy;
  logic [31:0] stat_reg;
  logic        stat_reg_new;
  logic        tx_idle;
  logic        tx_err;
  logic [31:0] tx_byte_count;

  io_tx_axi_if axi ();

  io_tx_scheduler #(
    .WORD_W         (32),
    .QUEUE_DEPTH    (16),
    .BYTES_PER_WORD (4),
    .TX_DEPTH       (16),
    .TX_FIFO_ADDR   (32'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .out_req       (out_req),
    .out_data      (out_data),
    .out_busy      (out_busy),
    .stat_reg      (stat_reg),
    .stat_reg_new  (stat_reg_new),
    .axi           (axi),
    .tx_idle       (tx_idle),
    .tx_err        (tx_err),
    .tx_byte_count (tx_byte_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q [$];
  int unsigned aw_delay = 0, w_delay = 0;
  int unsigned aw_cnt = 0, w_cnt = 0;
  int unsigned w_total = 0, b_total = 0;
  int unsigned err_b_idx = 32'hFFFF_FFFF;
  bit          hold_b = 1'b0, chk_len = 1'b0;
  bit          prev_aw_pend = 1'b0, prev_w_pend = 1'b0;
  logic [31:0] prev_awaddr, prev_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model drives readies for the next edge, then the monitor checks
  // the handshakes that edge will complete.
  always @(negedge clk) begin
    if (rst) begin
      axi.axi_awready = 1'b0;
      axi.axi_wready  = 1'b0;
      axi.axi_bvalid  = 1'b0;
      axi.axi_bresp   = 2'b00;
      aw_cnt = 0;
      w_cnt  = 0;
      prev_aw_pend = 1'b0;
      prev_w_pend  = 1'b0;
    end else begin
      if (axi.axi_awvalid === 1'b1) begin
        axi.axi_awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        axi.axi_awready = 1'b0;
        aw_cnt = 0;
      end
      if (axi.axi_wvalid === 1'b1) begin
        axi.axi_wready = (w_cnt >= w_delay);
        w_cnt++;
      end else begin
        axi.axi_wready = 1'b0;
        w_cnt = 0;
      end
      if (axi.axi_bready === 1'b1 && !hold_b) begin
        axi.axi_bvalid = 1'b1;
        axi.axi_bresp  = (b_total == err_b_idx) ? 2'b10 : 2'b00;
      end else begin
        axi.axi_bvalid = 1'b0;
        axi.axi_bresp  = 2'b00;
      end

      if (prev_aw_pend) begin
        chk("awvalid_hold", {31'b0, axi.axi_awvalid}, 32'd1);
        chk("awaddr_hold", axi.axi_awaddr, prev_awaddr);
      end
      if (prev_w_pend) begin
        chk("wvalid_hold", {31'b0, axi.axi_wvalid}, 32'd1);
        chk("wdata_hold", axi.axi_wdata, prev_wdata);
      end

      if (axi.axi_awvalid === 1'b1 && axi.axi_awready) begin
        chk("awaddr", axi.axi_awaddr, 32'd4);
        chk("awprot", {29'b0, axi.axi_awprot}, 32'd0);
        if (chk_len) chk("aw_len", aw_cnt, 32'd4);
      end
      if (axi.axi_wvalid === 1'b1 && axi.axi_wready) begin
        w_total++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got wdata %h expected no write", axi.axi_wdata);
        end else begin
          chk("wdata", axi.axi_wdata, {24'b0, exp_q.pop_front()});
        end
        chk("wstrb", {28'b0, axi.axi_wstrb}, 32'd1);
        if (chk_len) chk("w_len", w_cnt, 32'd1);
      end
      if (axi.axi_bvalid && axi.axi_bready === 1'b1) b_total++;

      prev_aw_pend = (axi.axi_awvalid === 1'b1) && !axi.axi_awready;
      prev_w_pend  = (axi.axi_wvalid === 1'b1) && !axi.axi_wready;
      prev_awaddr  = axi.axi_awaddr;
      prev_wdata   = axi.axi_wdata;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    if (out_busy === 1'b0) begin
      for (int unsigned b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
    out_req  = 1'b1;
    out_data = w;
    cyc(1);
    out_req  = 1'b0;
  endtask

  task automatic status(input logic [31:0] v);
    stat_reg     = v;
    stat_reg_new = 1'b1;
    cyc(1);
    stat_reg_new = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    cyc(3);
    while (!(tx_idle === 1'b1 && exp_q.size() == 0) && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, %0d bytes still expected", name, n, exp_q.size());
    end
  endtask

  task automatic wait_writes(input string name, input int unsigned target, input int budget);
    int n = 0;
    while (w_total < target && n < budget) begin
      cyc(1);
      n++;
    end
    chk(name, w_total, target);
  endtask

  initial begin
    int unsigned w_before;
    rst = 1'b1; out_req = 1'b0; out_data = '0; stat_reg = '0; stat_reg_new = 1'b0;
    cyc(2);
    chk("rst_awvalid", {31'b0, axi.axi_awvalid}, 32'd0);
    chk("rst_wvalid", {31'b0, axi.axi_wvalid}, 32'd0);
    chk("rst_bready", {31'b0, axi.axi_bready}, 32'd0);
    chk("rst_awaddr", axi.axi_awaddr, 32'd0);
    chk("rst_wdata", axi.axi_wdata, 32'd0);
    chk("rst_wstrb", {28'b0, axi.axi_wstrb}, 32'd1);
    chk("rst_tx_idle", {31'b0, tx_idle}, 32'd1);
    chk("rst_out_busy", {31'b0, out_busy}, 32'd0);
    chk("rst_tx_err", {31'b0, tx_err}, 32'd0);
    chk("rst_byte_count", tx_byte_count, 32'd0);
    rst = 1'b0;

    // credits start at zero: a loaded queue must wait for a status refresh
    push(32'h44434241);
    cyc(10);
    chk("no_credit_writes", w_total, 32'd0);
    chk("no_credit_awvalid", {31'b0, axi.axi_awvalid}, 32'd0);
    chk("loaded_not_idle", {31'b0, tx_idle}, 32'd0);
    status(32'h4);
    wait_done("t1_done", 100);
    chk("t1_byte_count", tx_byte_count, 32'd4);
    chk("t1_tx_idle", {31'b0, tx_idle}, 32'd1);

    // slow address channel, immediate data channel
    aw_delay = 3; chk_len = 1'b1;
    push(32'hD4C3B2A1);
    wait_done("t2_done", 200);
    chk_len = 1'b0; aw_delay = 0;
    chk("t2_b_total", b_total, 32'd8);
    chk("t2_byte_count", tx_byte_count, 32'd8);

    // one reload buys exactly TX_DEPTH bytes
    status(32'h8);
    for (int unsigned i = 0; i < 5; i++) push(32'h10203040 + i * 32'h01010101);
    status(32'h4);
    wait_writes("t3_first16", 24, 300);
    cyc(20);
    chk("t3_stall_writes", w_total, 32'd24);
    chk("t3_stall_awvalid", {31'b0, axi.axi_awvalid}, 32'd0);
    chk("t3_stall_not_idle", {31'b0, tx_idle}, 32'd0);
    status(32'h8);
    cyc(10);
    chk("t3_full_no_issue", w_total, 32'd24);
    status(32'h4);
    wait_done("t3_done", 200);
    chk("t3_writes", w_total, 32'd28);
    chk("t3_byte_count", tx_byte_count, 32'd28);

    // fill the queue with no credits; the 17th push must be dropped
    status(32'h8);
    for (int unsigned i = 0; i < 17; i++) begin
      push(32'hA0B0C0D0 + i);
      if (i == 14) chk("t4_busy_after15", {31'b0, out_busy}, 32'd0);
      if (i == 15) chk("t4_busy_after16", {31'b0, out_busy}, 32'd1);
    end
    chk("t4_exp_bytes", exp_q.size(), 32'd64);
    for (int unsigned k = 0; k < 4; k++) begin
      status(32'h4);
      wait_writes("t4_batch", 28 + 16 * (k + 1), 300);
      cyc(4);
    end
    wait_done("t4_done", 100);
    chk("t4_writes", w_total, 32'd92);
    chk("t4_byte_count", tx_byte_count, 32'd92);
    chk("t4_busy_clear", {31'b0, out_busy}, 32'd0);

    // SLVERR on the second byte is sticky but the word still completes
    err_b_idx = b_total + 1;
    status(32'h4);
    push(32'h55AA0F01);
    wait_done("t5_done", 100);
    chk("t5_tx_err", {31'b0, tx_err}, 32'd1);
    chk("t5_byte_count", tx_byte_count, 32'd96);
    cyc(5);
    chk("t5_tx_err_sticky", {31'b0, tx_err}, 32'd1);

    // reset while waiting on B: word, queue, error and counter all dropped
    hold_b = 1'b1;
    push(32'h11223344);
    push(32'h55667788);
    begin
      int n = 0;
      while (axi.axi_bready !== 1'b1 && n < 50) begin
        cyc(1);
        n++;
      end
    end
    chk("t6_in_resp", {31'b0, axi.axi_bready}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    cyc(1);
    rst = 1'b0;
    hold_b = 1'b0;
    w_before = w_total;
    chk("t6_tx_err", {31'b0, tx_err}, 32'd0);
    chk("t6_byte_count", tx_byte_count, 32'd0);
    chk("t6_tx_idle", {31'b0, tx_idle}, 32'd1);
    chk("t6_bready", {31'b0, axi.axi_bready}, 32'd0);
    chk("t6_awvalid", {31'b0, axi.axi_awvalid}, 32'd0);
    status(32'h4);
    cyc(20);
    chk("t6_queue_flushed", w_total, w_before);
    chk("t6_idle_after", {31'b0, tx_idle}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
